// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared state, sweep-mode and waveform encodings for the DDS sweep controller
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } sweep_state_t;

    typedef enum logic [1:0] {
        WAVE_OFF,
        WAVE_SQUARE,
        WAVE_SAW,
        WAVE_TRI
    } wavesel_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter flagging the last cycle of a dwell period
module dds_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clock_in,
    input  logic               rst_n_in,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               tc
);

    logic [DWELL_W-1:0] cnt;

    // reload on a new FTW value, otherwise count down and rest at zero
    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = cnt == '0;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: FTW sweep sequencer (single, sawtooth, up-down) driving a DDS core
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int DWELL_W = 16
) (
    input  logic               clock_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic               stop_in,
    input  logic [1:0]         mode_in,
    input  logic [WIDTH-1:0]   ftw_start_in,
    input  logic [WIDTH-1:0]   ftw_stop_in,
    input  logic [WIDTH-1:0]   ftw_step_in,
    input  logic [DWELL_W-1:0] dwell_in,
    input  logic [1:0]         wavesel_cfg_in,
    input  logic [11:0]        amp_cfg_in,
    output logic [WIDTH-1:0]   FTW_out,
    output logic [1:0]         wavesel_out,
    output logic [11:0]        amp_out,
    output logic               enable_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               dir_out
);

    sweep_state_t       state;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   lo, hi, step;
    logic [DWELL_W-1:0] dwell;
    logic               tc, accept, finish, degenerate, at_top, up_hit, dn_hit;
    logic [WIDTH:0]     up_sum, dn_diff;

    assign accept     = state == IDLE && start_in && !stop_in;
    assign degenerate = lo >= hi;
    assign at_top     = degenerate || FTW_out == hi;
    assign finish     = state == RAMP_UP && tc && mode == MODE_SINGLE && at_top;
    // one extra bit absorbs both the carry of the up step and the borrow of the down step
    assign up_sum     = {1'b0, FTW_out} + {1'b0, step};
    assign dn_diff    = {1'b0, FTW_out} - {1'b0, step};
    assign up_hit     = up_sum >= {1'b0, hi};
    assign dn_hit     = dn_diff[WIDTH] || dn_diff[WIDTH-1:0] <= lo;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clock_in (clock_in),
        .rst_n_in (rst_n_in),
        .load     (accept || (state != IDLE && tc)),
        .load_val (accept ? dwell_in : dwell),
        .tc       (tc)
    );

    // sweep FSM: latch config on start, step on each dwell expiry, abort on stop
    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            mode        <= MODE_SINGLE;
            lo          <= '0;
            hi          <= '0;
            step        <= '0;
            dwell       <= '0;
            FTW_out     <= '0;
            wavesel_out <= '0;
            amp_out     <= '0;
            enable_out  <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            dir_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (stop_in || finish) begin
                state       <= IDLE;
                FTW_out     <= '0;
                wavesel_out <= '0;
                amp_out     <= '0;
                enable_out  <= 1'b0;
                busy_out    <= 1'b0;
                dir_out     <= 1'b0;
                done_out    <= !stop_in;
            end else if (accept) begin
                state       <= RAMP_UP;
                mode        <= (mode_in == 2'b11) ? MODE_SINGLE : mode_in;
                lo          <= ftw_start_in;
                hi          <= ftw_stop_in;
                step        <= ftw_step_in;
                dwell       <= dwell_in;
                FTW_out     <= ftw_start_in;
                wavesel_out <= wavesel_cfg_in;
                amp_out     <= amp_cfg_in;
                enable_out  <= 1'b1;
                busy_out    <= 1'b1;
                dir_out     <= 1'b0;
            end else if (tc && state == RAMP_UP) begin
                if (at_top) begin
                    FTW_out <= lo;
                end else begin
                    FTW_out <= up_hit ? hi : up_sum[WIDTH-1:0];
                    if (up_hit && mode == MODE_UPDOWN) begin
                        state   <= RAMP_DOWN;
                        dir_out <= 1'b1;
                    end
                end
            end else if (tc && state == RAMP_DOWN) begin
                FTW_out <= dn_hit ? lo : dn_diff[WIDTH-1:0];
                if (dn_hit) begin
                    state   <= RAMP_UP;
                    dir_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: randomized and directed sweeps checked cycle by cycle against a list-based sweep model
module tb_dds_sweep_ctrl;

    typedef struct {
        int ftw;
        bit dir;
        bit busy;
        bit done;
    } rec_t;

    logic        clock_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic [1:0]  mode_in = '0;
    logic [11:0] ftw_start_in = '0;
    logic [11:0] ftw_stop_in = '0;
    logic [11:0] ftw_step_in = '0;
    logic [15:0] dwell_in = '0;
    logic [1:0]  wavesel_cfg_in = '0;
    logic [11:0] amp_cfg_in = '0;
    logic [11:0] FTW_out;
    logic [1:0]  wavesel_out;
    logic [11:0] amp_out;
    logic        enable_out, busy_out, done_out, dir_out;

    int   n_checks = 0;
    int   n_errors = 0;
    int   sweep_id = 0;
    rec_t exp_q[$];

    dds_sweep_ctrl #(.WIDTH(12), .DWELL_W(16)) dut (
        .clock_in       (clock_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .stop_in        (stop_in),
        .mode_in        (mode_in),
        .ftw_start_in   (ftw_start_in),
        .ftw_stop_in    (ftw_stop_in),
        .ftw_step_in    (ftw_step_in),
        .dwell_in       (dwell_in),
        .wavesel_cfg_in (wavesel_cfg_in),
        .amp_cfg_in     (amp_cfg_in),
        .FTW_out        (FTW_out),
        .wavesel_out    (wavesel_out),
        .amp_out        (amp_out),
        .enable_out     (enable_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .dir_out        (dir_out)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock_in = ~clock_in;

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] observed();
        return {FTW_out, dir_out, busy_out, enable_out, done_out, wavesel_out, amp_out};
    endfunction

    task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // expected per-cycle outputs after a start: the ramp as a list of values, each shown dwell+1 times
    task automatic build(input int md, input int lo, input int hi, input int st, input int dw, input int n);
        int per[$];
        bit pdir[$];
        bit single, finishes;
        single = md != 1 && md != 2;
        exp_q.delete();
        if (lo >= hi || st == 0) begin
            per.push_back(lo);
            pdir.push_back(1'b0);
        end else begin
            for (int v = lo; v < hi; v += st) begin
                per.push_back(v);
                pdir.push_back(1'b0);
            end
            per.push_back(hi);
            pdir.push_back(md == 2);
            if (md == 2)
                for (int v = hi - st; v > lo; v -= st) begin
                    per.push_back(v);
                    pdir.push_back(1'b1);
                end
        end
        finishes = single && (lo >= hi || st != 0);
        while (exp_q.size() < n) begin
            foreach (per[k])
                repeat (dw + 1) exp_q.push_back('{ftw: per[k], dir: pdir[k], busy: 1'b1, done: 1'b0});
            if (finishes) begin
                exp_q.push_back('{ftw: 0, dir: 1'b0, busy: 1'b0, done: 1'b1});
                while (exp_q.size() < n) exp_q.push_back('{ftw: 0, dir: 1'b0, busy: 1'b0, done: 1'b0});
            end
        end
    endtask

    // start a sweep, compare n cycles, optionally abort at cycle stop_at, then stop back to idle
    task automatic run_sweep(input int md, input int lo, input int hi, input int st, input int dw,
                             input int n, input int stop_at, input bit noise);
        logic [1:0]  ws;
        logic [11:0] am;
        rec_t        r;
        ws = 2'($urandom);
        am = 12'($urandom);
        sweep_id++;
        build(md, lo, hi, st, dw, n);
        mode_in        = md[1:0];
        ftw_start_in   = lo[11:0];
        ftw_stop_in    = hi[11:0];
        ftw_step_in    = st[11:0];
        dwell_in       = dw[15:0];
        wavesel_cfg_in = ws;
        amp_cfg_in     = am;
        start_in       = 1'b1;
        stop_in        = 1'b0;
        @(posedge clock_in); #1;
        start_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            r = exp_q[i];
            check($sformatf("sweep%0d_c%0d", sweep_id, i), observed(),
                  {r.ftw[11:0], r.dir, r.busy, r.busy, r.done, r.busy ? ws : 2'b0, r.busy ? am : 12'b0});
            if (i == stop_at) begin
                stop_in = 1'b1;
                @(posedge clock_in); #1;
                stop_in = 1'b0;
                check($sformatf("sweep%0d_abort", sweep_id), observed(), 30'b0);
                return;
            end
            if (noise) begin
                start_in       = r.busy && $urandom_range(0, 3) == 0;
                mode_in        = 2'($urandom);
                ftw_start_in   = 12'($urandom);
                ftw_stop_in    = 12'($urandom);
                ftw_step_in    = 12'($urandom);
                dwell_in       = 16'($urandom_range(0, 3));
                wavesel_cfg_in = 2'($urandom);
                amp_cfg_in     = 12'($urandom);
            end
            @(posedge clock_in); #1;
        end
        start_in = 1'b0;
        stop_in  = 1'b1;
        @(posedge clock_in); #1;
        stop_in = 1'b0;
        check($sformatf("sweep%0d_end", sweep_id), observed(), 30'b0);
    endtask

    // stimulus: reset, directed scenarios, abort/reset corner cases, randomized sweeps
    initial begin
        int lo, hi, st;
        #1;
        check("reset_state", observed(), 30'b0);
        #11 rst_n_in = 1'b1;
        @(posedge clock_in); #1;
        check("idle_after_reset", observed(), 30'b0);

        run_sweep(0, 2, 10, 4, 1, 10, -1, 1'b0);
        run_sweep(0, 4090, 4095, 8, 0, 5, -1, 1'b0);
        run_sweep(2, 0, 6, 3, 0, 14, -1, 1'b1);
        run_sweep(1, 1, 5, 2, 0, 14, -1, 1'b1);
        run_sweep(0, 2, 40, 4, 3, 10, 2, 1'b0);
        run_sweep(0, 9, 9, 1, 1, 6, -1, 1'b0);
        run_sweep(1, 20, 5, 3, 0, 8, -1, 1'b0);
        run_sweep(2, 7, 7, 2, 1, 8, -1, 1'b0);
        run_sweep(0, 3, 9, 0, 0, 8, -1, 1'b0);
        run_sweep(3, 3, 3, 0, 0, 6, -1, 1'b0);
        run_sweep(2, 4000, 4095, 50, 1, 16, -1, 1'b1);

        ftw_start_in = 12'd5;
        ftw_stop_in  = 12'd50;
        ftw_step_in  = 12'd5;
        start_in     = 1'b1;
        stop_in      = 1'b1;
        @(posedge clock_in); #1;
        check("start_stop_same", observed(), 30'b0);
        start_in = 1'b0;
        stop_in  = 1'b0;
        @(posedge clock_in); #1;
        check("start_stop_stays_idle", observed(), 30'b0);

        mode_in        = 2'b10;
        ftw_start_in   = 12'd0;
        ftw_stop_in    = 12'd6;
        ftw_step_in    = 12'd3;
        dwell_in       = 16'd0;
        wavesel_cfg_in = 2'd3;
        amp_cfg_in     = 12'hABC;
        start_in       = 1'b1;
        @(posedge clock_in); #1;
        start_in = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        check("pre_reset_busy", observed(), {12'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 12'hABC});
        #2 rst_n_in = 1'b0;
        #1;
        check("async_reset", observed(), 30'b0);
        @(posedge clock_in); #1;
        check("held_reset", observed(), 30'b0);
        #3 rst_n_in = 1'b1;
        repeat (3) begin
            @(posedge clock_in); #1;
            check("post_reset_idle", observed(), 30'b0);
        end
        run_sweep(0, 1, 4, 1, 0, 6, -1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            lo = $urandom_range(0, 63);
            hi = $urandom_range(0, 63);
            st = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) begin
                lo += 4030;
                hi += 4030;
                st += $urandom_range(0, 60);
            end
            run_sweep($urandom_range(0, 3), lo, hi, st, $urandom_range(0, 2), 40,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, FTW width matching the DDS top-level FTW_IN width.
REQ-002 SHALL have parameter DWELL_W, default 16, dwell counter width.
REQ-003 SHALL have port clock_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_in, input, 1, start a sweep when idle.
REQ-006 SHALL have port stop_in, input, 1, abort a sweep.
REQ-007 SHALL have port mode_in, input, 2: 00 single, 01 repeat-sawtooth, 10 up-down, 11 reserved (treated as 00).
REQ-008 SHALL have ports ftw_start_in, ftw_stop_in and ftw_step_in, each input, WIDTH, sweep bounds and increment.
REQ-009 SHALL have port dwell_in, input, DWELL_W, extra cycles each FTW value is held.
REQ-010 SHALL have ports wavesel_cfg_in (input, 2) and amp_cfg_in (input, 12), waveform select and amplitude to apply during the sweep.
REQ-011 SHALL have port FTW_out, output, WIDTH, drives the DDS FTW_IN.
REQ-012 SHALL have ports wavesel_out (output, 2) and amp_out (output, 12), drive the DDS wavesel_in and amp_in.
REQ-013 SHALL have port enable_out, output, 1, drives the DDS enable_in.
REQ-014 SHALL have ports busy_out (output, 1, sweep active), done_out (output, 1, one-cycle completion pulse) and dir_out (output, 1, 0 = up, 1 = down).

Function
REQ-015 SHALL implement FSM states IDLE, RAMP_UP and RAMP_DOWN; all outputs SHALL be registered.
REQ-016 In IDLE, start_in=1 with stop_in=0 SHALL latch all cfg inputs, and the next cycle SHALL show RAMP_UP, FTW_out=ftw_start, enable_out=1 and busy_out=1.
REQ-017 Cfg inputs SHALL be ignored while busy; start_in while busy SHALL be ignored.
REQ-018 Each FTW value SHALL be held dwell+1 cycles; dwell=0 SHALL mean a new value every cycle.
REQ-019 RAMP_UP step: next = FTW_out + step, computed WIDTH+1 bits wide; if next >= ftw_stop or the sum overflows, FTW_out SHALL be clamped to ftw_stop.
REQ-020 RAMP_DOWN step: next = FTW_out - step, computed signed WIDTH+1 bits wide; if next <= ftw_start or the subtraction underflows, FTW_out SHALL be clamped to ftw_start.
REQ-021 Reaching ftw_stop after its full dwell in mode 00 SHALL return to IDLE and pulse done_out for 1 cycle, with enable_out=0, busy_out=0 and FTW_out=0 in that cycle.
REQ-022 Reaching ftw_stop after its full dwell in mode 01 SHALL reload FTW_out=ftw_start the next cycle and SHALL NOT pulse done_out.
REQ-023 Reaching ftw_stop after its full dwell in mode 10 SHALL enter RAMP_DOWN with dir_out=1.
REQ-024 Reaching ftw_start after its full dwell in mode 10 SHALL re-enter RAMP_UP with dir_out=0.
REQ-025 stop_in=1 in any state SHALL force IDLE the next cycle: outputs return to reset values, no done_out.
REQ-026 Simultaneous start_in and stop_in SHALL let stop win.
REQ-027 If ftw_start >= ftw_stop, the sweep SHALL hold ftw_start for one dwell, then mode 00 SHALL complete per REQ-021 and modes 01/10 SHALL hold ftw_start until stop_in.
REQ-028 If ftw_step = 0, FTW_out SHALL hold ftw_start until stop_in; in mode 00 the sweep SHALL complete only if ftw_start >= ftw_stop.
REQ-029 While busy, wavesel_out and amp_out SHALL equal the latched cfg values; in IDLE they SHALL be 0.

Reset
REQ-030 rst_n_in=0 SHALL asynchronously force IDLE, and every output SHALL be 0: FTW_out, amp_out, wavesel_out, enable_out, busy_out, done_out and dir_out.
REQ-031 Reset asserted mid-sweep SHALL discard the latched config; after release, operation SHALL resume only on a new start_in.

Structure
REQ-032 A shared package dds_ctrl_pkg SHALL hold the state enum, the mode encodings (MODE_SINGLE, MODE_REPEAT, MODE_UPDOWN) and the wavesel encodings (off, square, sawtooth, triangle).
REQ-033 One sub-module, dds_dwell_timer, SHALL provide a load/count/terminal-count pulse of width DWELL_W, reset by rst_n_in.

Verification
REQ-034 Scenario (mode 00): start=2, stop=10, step=4, dwell=1 -> FTW_out sequence 2,2,6,6,10,10, then done_out=1 for 1 cycle with enable_out=0.
REQ-035 Scenario (clamp): start=4090, stop=4095, step=8, WIDTH=12 -> 4090 then 4095, no wrap, then done.
REQ-036 Scenario (mode 10): start=0, stop=6, step=3, dwell=0 -> 0,3,6,3,0,3,... with dir_out toggling on entry to 6 and 0.
REQ-037 Scenario (mode 01): start=1, stop=5, step=2, dwell=0 -> 1,3,5,1,3,5,..., done_out never asserted.
REQ-038 Scenario (abort): stop_in during the 3rd dwell cycle -> next cycle IDLE, all outputs 0, no done_out; start and stop together from IDLE -> stays IDLE.
REQ-039 Scenario (reset): rst_n_in low mid-sweep -> outputs 0 with no clock edge; start_in issued while busy -> FTW sequence unchanged.
